alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Upstream stage for the 4-bit mini_processor ALU (ctrl encoding: 00 ADD, 01 SUB, 10 AND, 11 OR).
- Holds a small loadable program of ALU instructions.
- On start, issues the instructions one at a time to the ALU, drives A/B/ctrl, and captures each result into an accumulator.
- An instruction can take the accumulator as its A operand, so ALU operations can be chained without host involvement.

Parameters:
DEPTH, 16, number of program-memory entries
AW, 4, program address width; must equal log2(DEPTH)
DATA_W, 4, ALU operand/result width; fixed at 4 to match the ALU

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
prog_we  input  1  program write strobe
prog_addr  input  AW  program write address
prog_data  input  11  instruction word: [10]=use_acc, [9:8]=ctrl, [7:4]=A, [3:0]=B
prog_len  input  AW+1  number of instructions to run, 0..DEPTH
start  input  1  single-cycle run request
alu_a  output  4  ALU operand A (registered)
alu_b  output  4  ALU operand B (registered)
alu_ctrl  output  2  ALU opcode (registered)
alu_result  input  4  combinational result returned from the ALU
acc_out  output  4  last captured ALU result
result_valid  output  1  one-cycle pulse per captured result
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse at end of run
pc_out  output  AW  index of the current instruction

Behaviour:
Reset and memory
- One clock. Reset is synchronous and active-high.
- rst forces state=IDLE; alu_a, alu_b, alu_ctrl, acc_out, pc_out, result_valid, busy and done all go to 0.
- Program memory is not reset.
- rst has priority over every other input, including mid-run. The run is abandoned and the next start begins again at pc 0.

Program loading
- prog_we writes prog_data to mem[prog_addr] at the edge, but only in IDLE.
- prog_we is ignored while busy.

FSM (IDLE, ISSUE, CAPTURE, DONE)
- IDLE: on an edge with start=1:
  - pc <= 0.
  - state <= ISSUE, or state <= DONE if the effective length is 0.
  - Effective length = min(prog_len, DEPTH), sampled once at start and held for the whole run.
- ISSUE:
  - alu_ctrl <= mem[pc][9:8].
  - alu_b <= mem[pc][3:0].
  - alu_a <= acc_out if mem[pc][10]=1, else mem[pc][7:4].
  - state <= CAPTURE.
- CAPTURE:
  - acc_out <= alu_result (operands have been stable for a full cycle).
  - result_valid high for the following cycle.
  - If pc == len-1, state <= DONE; else pc <= pc+1 and state <= ISSUE.
- DONE: done is high for exactly this one cycle; state <= IDLE.

Timing and side conditions
- Each instruction takes 2 cycles.
- With start sampled at edge 0, done is high in the cycle after edge 2N.
- For the last instruction, result_valid and done are high in the same cycle.
- start is ignored while busy; there is no queuing.
- alu_a, alu_b and alu_ctrl hold their last values when not in ISSUE.
- Arithmetic wraps mod 16 inside the ALU. The sequencer stores the 4 bits unchanged; there is no carry or borrow.
- use_acc on the first instruction uses acc_out left over from the previous run, or 0 after reset.

Test Plan:
1. mem[0]={0,00,0101,0011}, prog_len=1, start -> alu_a=0101, alu_b=0011, alu_ctrl=00; acc_out=1000; result_valid and done high in cycle after edge 2; busy low after edge 3.
2. Chain program:
   - Program: ADD 5,3; SUB acc,0001 (use_acc); AND acc,1100 (use_acc); OR acc,0011 (use_acc); prog_len=4.
   - Required: acc_out sequence 1000, 0111, 0100, 0111; 4 result_valid pulses; done in cycle after edge 8.
3. Wrap: SUB 0001,0011 -> acc_out=1110; OR 1010,1100 -> 1110; AND 1010,1100 -> 1000.
4. prog_len=0, start -> done high in cycle after edge 0; no result_valid; acc_out unchanged. prog_len=20 with DEPTH=16 -> exactly 16 result_valid pulses.
5. During a run, pulse start and write prog_we to mem[0] -> run is unaffected, pc sequence unchanged; rerun shows original mem[0] result.
6. Assert rst during CAPTURE of instruction 2 of scenario 2 -> next edge: all outputs 0, busy=0. Restart -> identical results to scenario 2 (first ADD gives 1000).

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Interface between the alu_sequencer and its host/ALU environment.
// The master side loads the program, starts runs and supplies the ALU result; the slave side is the sequencer.
interface alu_sequencer_if #(
  parameter int AW     = 4,
  parameter int DATA_W = 4
);
  logic              prog_we;
  logic [AW-1:0]     prog_addr;
  logic [10:0]       prog_data;
  logic [AW:0]       prog_len;
  logic              start;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [1:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] acc_out;
  logic              result_valid;
  logic              busy;
  logic              done;
  logic [AW-1:0]     pc_out;

  modport master (
    output prog_we, prog_addr, prog_data, prog_len, start, alu_result,
    input  alu_a, alu_b, alu_ctrl, acc_out, result_valid, busy, done, pc_out
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, prog_len, start, alu_result,
    output alu_a, alu_b, alu_ctrl, acc_out, result_valid, busy, done, pc_out
  );
endinterface

// File: rtl/alu_sequencer.sv
// Runs a small loadable program of 4-bit ALU instructions, two cycles per instruction,
// chaining results through an accumulator.
//
// state   | meaning
// IDLE    | waiting for start; program memory writable
// ISSUE   | drive A/B/ctrl from mem[pc] (A may come from the accumulator)
// CAPTURE | latch ALU result into acc_out, advance pc or finish
// DONE    | one-cycle done pulse, then back to IDLE
module alu_sequencer #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int DATA_W = 4
) (
  input logic            clk,
  input logic            rst,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  state_t            state;
  logic [10:0]       mem [DEPTH];
  logic [AW-1:0]     pc;
  logic [AW:0]       len;
  logic [AW:0]       eff_len;
  logic [10:0]       instr;
  logic [DATA_W-1:0] alu_a_q, alu_b_q, acc_q;
  logic [1:0]        alu_ctrl_q;
  logic              result_valid_q, busy_q, done_q;

  assign instr   = mem[pc];
  assign eff_len = (bus.prog_len > DEPTH_L) ? DEPTH_L : bus.prog_len;

  // Program memory has no reset; writes only land while the sequencer is idle.
  always_ff @(posedge clk) begin
    if (!rst && bus.prog_we && state == IDLE)
      mem[bus.prog_addr] <= bus.prog_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      pc             <= '0;
      len            <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_ctrl_q     <= '0;
      acc_q          <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            pc     <= '0;
            len    <= eff_len;
            busy_q <= 1'b1;
            if (eff_len == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          alu_ctrl_q <= instr[9:8];
          alu_b_q    <= instr[3:0];
          alu_a_q    <= instr[10] ? acc_q : instr[7:4];
          state      <= CAPTURE;
        end
        CAPTURE: begin
          acc_q          <= bus.alu_result;
          result_valid_q <= 1'b1;
          // len is at least 1 here, so len-1 cannot underflow.
          if ({1'b0, pc} == len - (AW + 1)'(1)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            pc    <= pc + 1'b1;
            state <= ISSUE;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_ctrl     = alu_ctrl_q;
  assign bus.acc_out      = acc_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.pc_out       = pc;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a reference ALU drives alu_result, and a scoreboard
// of expected operands/results is checked on every result_valid pulse.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst;

  alu_sequencer_if #(.AW(4), .DATA_W(4)) bus ();

  alu_sequencer #(.DEPTH(16), .AW(4), .DATA_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_f(input logic [1:0] c, input logic [3:0] a, input logic [3:0] b);
    case (c)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  always_comb bus.alu_result = alu_f(bus.alu_ctrl, bus.alu_a, bus.alu_b);

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] c;
    logic [3:0] r;
    logic [3:0] pc;
  } exp_t;

  exp_t        sb[$];
  logic [10:0] prog [16];
  logic [3:0]  model_acc;
  int          n_cmp = 0;
  int          n_err = 0;
  int          rv_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.result_valid === 1'b1) begin
      exp_t e;
      rv_count++;
      if (sb.size() == 0) begin
        check("sb_unexpected_result", 32'(bus.acc_out), 32'hffff_ffff);
      end else begin
        e = sb.pop_front();
        check("sb_alu_a", 32'(bus.alu_a), 32'(e.a));
        check("sb_alu_b", 32'(bus.alu_b), 32'(e.b));
        check("sb_alu_ctrl", 32'(bus.alu_ctrl), 32'(e.c));
        check("sb_acc_out", 32'(bus.acc_out), 32'(e.r));
        check("sb_pc_out", 32'(bus.pc_out), 32'(e.pc));
      end
    end
  end

  task automatic load(input logic [3:0] addr, input logic [10:0] data);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr;
    bus.prog_data = data;
    prog[addr]    = data;
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  // Pushes the expected results, runs the program and checks done timing; optionally
  // pulses start and a memory write mid-run, which must both be ignored.
  task automatic run_prog(input logic [4:0] len_in, input int exp_done, input bit inject);
    int n;
    int got;
    logic [3:0] a, r;
    n = (len_in > 5'd16) ? 16 : int'(len_in);
    for (int i = 0; i < n; i++) begin
      a = prog[i][10] ? model_acc : prog[i][7:4];
      r = alu_f(prog[i][9:8], a, prog[i][3:0]);
      sb.push_back('{a, prog[i][3:0], prog[i][9:8], r, (i == n - 1) ? 4'(i) : 4'(i + 1)});
      model_acc = r;
    end
    rv_count = 0;
    @(negedge clk);
    bus.prog_len = len_in;
    bus.start    = 1'b1;
    got = -1;
    for (int k = 0; k < 100 && got < 0; k++) begin
      @(negedge clk);
      bus.start     = inject && (k == 3);
      bus.prog_we   = inject && (k == 3);
      bus.prog_addr = 4'h0;
      bus.prog_data = 11'h7ff;
      if (bus.done === 1'b1) got = k;
    end
    bus.start   = 1'b0;
    bus.prog_we = 1'b0;
    check("done_cycle", 32'(got), 32'(exp_done));
    @(negedge clk);
    check("busy_after_done", 32'(bus.busy), 32'd0);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("result_valid_count", 32'(rv_count), 32'(n));
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.prog_len  = '0;
    bus.start     = 1'b0;
    model_acc     = 4'h0;
    for (int i = 0; i < 16; i++) prog[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_alu_a", 32'(bus.alu_a), 32'd0);
    check("rst_alu_b", 32'(bus.alu_b), 32'd0);
    check("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    check("rst_acc_out", 32'(bus.acc_out), 32'd0);
    check("rst_pc_out", 32'(bus.pc_out), 32'd0);
    check("rst_flags", 32'({bus.result_valid, bus.busy, bus.done}), 32'd0);
    rst = 1'b0;

    // single ADD 5+3
    load(4'd0, {1'b0, 2'b00, 4'b0101, 4'b0011});
    run_prog(5'd1, 2, 1'b0);
    check("s1_alu_a", 32'(bus.alu_a), 32'h5);
    check("s1_alu_b", 32'(bus.alu_b), 32'h3);
    check("s1_alu_ctrl", 32'(bus.alu_ctrl), 32'h0);
    check("s1_acc_out", 32'(bus.acc_out), 32'h8);

    // chain through the accumulator: 8, 7, 4, 7
    load(4'd1, {1'b1, 2'b01, 4'b0000, 4'b0001});
    load(4'd2, {1'b1, 2'b10, 4'b0000, 4'b1100});
    load(4'd3, {1'b1, 2'b11, 4'b0000, 4'b0011});
    run_prog(5'd4, 8, 1'b0);
    check("s2_acc_final", 32'(bus.acc_out), 32'h7);

    // wrap and logic ops: 1110, 1110, 1000
    load(4'd0, {1'b0, 2'b01, 4'b0001, 4'b0011});
    load(4'd1, {1'b0, 2'b11, 4'b1010, 4'b1100});
    load(4'd2, {1'b0, 2'b10, 4'b1010, 4'b1100});
    run_prog(5'd3, 6, 1'b0);
    check("s3_acc_final", 32'(bus.acc_out), 32'h8);

    // zero length: immediate done, accumulator untouched
    run_prog(5'd0, 0, 1'b0);
    check("s4_len0_acc", 32'(bus.acc_out), 32'h8);

    // over-long length clamps to 16 entries
    for (int i = 0; i < 16; i++)
      load(4'(i), {1'(i % 3 == 0), 2'(i), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))});
    run_prog(5'd20, 32, 1'b0);

    // start and prog_we mid-run are ignored
    load(4'd0, {1'b0, 2'b00, 4'b0101, 4'b0011});
    load(4'd1, {1'b1, 2'b01, 4'b0000, 4'b0001});
    load(4'd2, {1'b1, 2'b10, 4'b0000, 4'b1100});
    load(4'd3, {1'b1, 2'b11, 4'b0000, 4'b0011});
    run_prog(5'd4, 8, 1'b1);
    run_prog(5'd4, 8, 1'b0);
    check("s5_rerun_acc", 32'(bus.acc_out), 32'h7);

    // reset during CAPTURE of the second instruction, then rerun from pc 0
    sb.push_back('{4'h5, 4'h3, 2'b00, 4'h8, 4'h1});
    @(negedge clk);
    bus.prog_len = 5'd4;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("s6_busy_mid", 32'(bus.busy), 32'd1);
    check("s6_pc_mid", 32'(bus.pc_out), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("s6_rst_operands", 32'({bus.alu_a, bus.alu_b, bus.alu_ctrl}), 32'd0);
    check("s6_rst_acc_pc", 32'({bus.acc_out, bus.pc_out}), 32'd0);
    check("s6_rst_flags", 32'({bus.result_valid, bus.busy, bus.done}), 32'd0);
    check("s6_sb_empty", 32'(sb.size()), 32'd0);
    rst = 1'b0;
    model_acc = 4'h0;
    run_prog(5'd4, 8, 1'b0);
    check("s6_rerun_acc", 32'(bus.acc_out), 32'h7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
